// File: rtl/pipeline_controller_pkg.sv
// Shared encodings for the pipeline controller: opcodes, functs, ALU/mux codes,
// sequencer state and the decoded control bundle.
package pipeline_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_NOR = 4'b0011;
    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b1100;
    localparam logic [3:0] ALU_SLT = 4'b1101;

    localparam logic [1:0] OUT_ALU = 2'b00;
    localparam logic [1:0] OUT_HI  = 2'b01;
    localparam logic [1:0] OUT_LO  = 2'b10;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_REG    = 2'b11;

    localparam int CNT_W = 6;

    typedef enum logic {SEQ_IDLE, SEQ_BUSY} seq_state_t;

    typedef struct packed {
        logic       regwrite;
        logic       regdst;
        logic       alusrc;
        logic [3:0] aluctrl;
        logic       memwrite;
        logic       memtoreg;
        logic       se_ze;
        logic [1:0] outselect;
        logic       branch;
        logic [1:0] pcsrc;
        logic       is_mult;
        logic       mult_sign;
        logic       hilo_use;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/pipeline_controller_if.sv
// Decode-feedback / control bundle between data path (master) and controller (slave).
interface pipeline_controller_if;
    logic [5:0] op_code;
    logic [5:0] control_unit_funct;
    logic       eq_ne;
    logic       regwrite_d;
    logic       regdst_d;
    logic       alusrc_d;
    logic [3:0] aluctrl_d;
    logic       memwrite_d;
    logic       memtoreg_d;
    logic       se_ze;
    logic [1:0] outselect_d;
    logic       start_mult;
    logic       mult_sign;
    logic       output_branch;
    logic [1:0] pcsrc;
    logic       stall;
    logic       illegal_instr;

    modport master (
        output op_code, control_unit_funct, eq_ne,
        input  regwrite_d, regdst_d, alusrc_d, aluctrl_d, memwrite_d, memtoreg_d,
               se_ze, outselect_d, start_mult, mult_sign, output_branch, pcsrc,
               stall, illegal_instr
    );

    modport slave (
        input  op_code, control_unit_funct, eq_ne,
        output regwrite_d, regdst_d, alusrc_d, aluctrl_d, memwrite_d, memtoreg_d,
               se_ze, outselect_d, start_mult, mult_sign, output_branch, pcsrc,
               stall, illegal_instr
    );
endinterface

// File: rtl/pipeline_controller_mult_sequencer.sv
// Multiply sequencer: IDLE/BUSY FSM with a latency down-counter and start pulse.
module mult_sequencer
    import pipeline_ctrl_pkg::*;
#(
    parameter int MULT_LATENCY = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic mult_req,
    output logic start_mult,
    output logic busy
);
    seq_state_t       state_reg;
    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= SEQ_IDLE;
            count_reg <= '0;
        end else begin
            case (state_reg)
                SEQ_IDLE: begin
                    if (mult_req) begin
                        state_reg <= SEQ_BUSY;
                        count_reg <= CNT_W'(MULT_LATENCY - 1);
                    end
                end
                SEQ_BUSY: begin
                    // HI/LO become readable in the IDLE cycle after count reaches zero
                    if (count_reg == '0) begin
                        state_reg <= SEQ_IDLE;
                    end else begin
                        count_reg <= count_reg - 1'b1;
                    end
                end
                default: state_reg <= SEQ_IDLE;
            endcase
        end
    end

    assign start_mult = (state_reg == SEQ_IDLE) && mult_req && !reset;
    assign busy       = (state_reg == SEQ_BUSY);
endmodule

// File: rtl/pipeline_controller.sv
// MIPS-style pipeline control unit with multiply sequencer and HI/LO stall logic.
// Optional: define PIPELINE_CTRL_MULTU_EN to decode multu (unsigned multiply).
module pipeline_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int MULT_LATENCY = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    pipeline_controller_if.slave  bus
);
    ctrl_t dec;
    logic  seq_start;
    logic  seq_busy;
    logic  stall_int;

    always_comb begin
        dec = '0;
        case (bus.op_code)
            OP_RTYPE: begin
                dec.regwrite = 1'b1;
                dec.regdst   = 1'b1;
                case (bus.control_unit_funct)
                    FN_ADD, FN_ADDU: dec.aluctrl = ALU_ADD;
                    FN_SUB, FN_SUBU: dec.aluctrl = ALU_SUB;
                    FN_AND:          dec.aluctrl = ALU_AND;
                    FN_OR:           dec.aluctrl = ALU_OR;
                    FN_XOR:          dec.aluctrl = ALU_XOR;
                    FN_NOR:          dec.aluctrl = ALU_NOR;
                    FN_SLT:          dec.aluctrl = ALU_SLT;
                    FN_MFHI: begin
                        dec.outselect = OUT_HI;
                        dec.hilo_use  = 1'b1;
                    end
                    FN_MFLO: begin
                        dec.outselect = OUT_LO;
                        dec.hilo_use  = 1'b1;
                    end
                    FN_JR: begin
                        dec.regwrite = 1'b0;
                        dec.pcsrc    = PC_REG;
                    end
                    FN_MULT: begin
                        dec.regwrite  = 1'b0;
                        dec.is_mult   = 1'b1;
                        dec.mult_sign = 1'b1;
                        dec.hilo_use  = 1'b1;
                    end
`ifdef PIPELINE_CTRL_MULTU_EN
                    FN_MULTU: begin
                        dec.regwrite = 1'b0;
                        dec.is_mult  = 1'b1;
                        dec.hilo_use = 1'b1;
                    end
`endif
                    default: begin
                        dec         = '0;
                        dec.illegal = 1'b1;
                    end
                endcase
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LW, OP_SW: begin
                dec.alusrc   = 1'b1;
                dec.regwrite = (bus.op_code != OP_SW);
                dec.se_ze    = (bus.op_code != OP_ANDI) && (bus.op_code != OP_ORI);
                dec.memtoreg = (bus.op_code == OP_LW);
                dec.memwrite = (bus.op_code == OP_SW);
                case (bus.op_code)
                    OP_ANDI: dec.aluctrl = ALU_AND;
                    OP_ORI:  dec.aluctrl = ALU_OR;
                    OP_SLTI: dec.aluctrl = ALU_SLT;
                    default: dec.aluctrl = ALU_ADD;
                endcase
            end
            OP_BEQ, OP_BNE: begin
                dec.branch  = 1'b1;
                dec.se_ze   = 1'b1;
                dec.aluctrl = ALU_SUB;
                if ((bus.op_code == OP_BEQ) == bus.eq_ne) begin
                    dec.pcsrc = PC_BRANCH;
                end
            end
            OP_J: dec.pcsrc = PC_JUMP;
            default: dec.illegal = 1'b1;
        endcase
    end

    mult_sequencer #(
        .MULT_LATENCY (MULT_LATENCY)
    ) u_seq (
        .clk        (clk),
        .reset      (reset),
        .mult_req   (dec.is_mult),
        .start_mult (seq_start),
        .busy       (seq_busy)
    );

    assign stall_int = seq_busy && dec.hilo_use && !reset;

    // Reset forces every output low; a stall suppresses side effects only.
    always_comb begin
        bus.regwrite_d    = 1'b0;
        bus.regdst_d      = 1'b0;
        bus.alusrc_d      = 1'b0;
        bus.aluctrl_d     = 4'b0000;
        bus.memwrite_d    = 1'b0;
        bus.memtoreg_d    = 1'b0;
        bus.se_ze         = 1'b0;
        bus.outselect_d   = 2'b00;
        bus.start_mult    = 1'b0;
        bus.mult_sign     = 1'b0;
        bus.output_branch = 1'b0;
        bus.pcsrc         = PC_PLUS4;
        bus.stall         = 1'b0;
        bus.illegal_instr = 1'b0;
        if (!reset) begin
            bus.regwrite_d    = dec.regwrite && !stall_int;
            bus.regdst_d      = dec.regdst;
            bus.alusrc_d      = dec.alusrc;
            bus.aluctrl_d     = dec.aluctrl;
            bus.memwrite_d    = dec.memwrite && !stall_int;
            bus.memtoreg_d    = dec.memtoreg;
            bus.se_ze         = dec.se_ze;
            bus.outselect_d   = dec.outselect;
            bus.start_mult    = seq_start && !stall_int;
            bus.mult_sign     = dec.mult_sign;
            bus.output_branch = dec.branch && !stall_int;
            bus.pcsrc         = stall_int ? PC_PLUS4 : dec.pcsrc;
            bus.stall         = stall_int;
            bus.illegal_instr = dec.illegal;
        end
    end
endmodule

// File: tb/tb_pipeline_controller.sv
// Directed testbench for pipeline_controller with MULT_LATENCY = 4.
module tb_pipeline_controller;
    logic clk;
    logic reset;
    int   tests;
    int   fails;

    pipeline_controller_if bus ();

    pipeline_controller #(
        .MULT_LATENCY (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {regwrite, regdst, alusrc, aluctrl, memwrite, memtoreg, se_ze, outselect,
    //  start_mult, mult_sign, output_branch, pcsrc, stall, illegal}
    function automatic logic [18:0] observed();
        return {bus.regwrite_d, bus.regdst_d, bus.alusrc_d, bus.aluctrl_d,
                bus.memwrite_d, bus.memtoreg_d, bus.se_ze, bus.outselect_d,
                bus.start_mult, bus.mult_sign, bus.output_branch, bus.pcsrc,
                bus.stall, bus.illegal_instr};
    endfunction

    function automatic logic [18:0] ev(input logic rw, input logic rd, input logic as,
                                       input logic [3:0] alu, input logic mw,
                                       input logic mtr, input logic se,
                                       input logic [1:0] os, input logic sm,
                                       input logic ms, input logic br,
                                       input logic [1:0] pc, input logic st,
                                       input logic il);
        return {rw, rd, as, alu, mw, mtr, se, os, sm, ms, br, pc, st, il};
    endfunction

    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic eq);
        bus.op_code            = op;
        bus.control_unit_funct = fn;
        bus.eq_ne              = eq;
    endtask

    task automatic check(input string tag, input logic [18:0] expected);
        logic [18:0] got;
        @(negedge clk);
        got = observed();
        tests++;
        assert (got === expected)
            $display("[TB] %-14s ok  outputs=%05h", tag, got);
        else begin
            fails++;
            $error("FAIL %s observed=%05h expected=%05h", tag, got, expected);
        end
        @(posedge clk);
        #1;
    endtask

    localparam logic [18:0] ZERO   = 19'h0;
    localparam logic [5:0]  RT     = 6'b000000;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        drive(RT, 6'b100000, 1'b0);

        check("reset_c0", ZERO);
        check("reset_c1", ZERO);
        reset = 1'b0;
        check("add",      ev(1,1,0,4'b0100,0,0,0,2'b00,0,0,0,2'b00,0,0));

        drive(6'b000100, 6'b000000, 1'b1);
        check("beq_taken",  ev(0,0,0,4'b1100,0,0,1,2'b00,0,0,1,2'b01,0,0));
        drive(6'b000100, 6'b000000, 1'b0);
        check("beq_nottkn", ev(0,0,0,4'b1100,0,0,1,2'b00,0,0,1,2'b00,0,0));
        drive(6'b000101, 6'b000000, 1'b0);
        check("bne_taken",  ev(0,0,0,4'b1100,0,0,1,2'b00,0,0,1,2'b01,0,0));
        drive(6'b000010, 6'b000000, 1'b0);
        check("j",          ev(0,0,0,4'b0000,0,0,0,2'b00,0,0,0,2'b10,0,0));
        drive(6'b100011, 6'b000000, 1'b0);
        check("lw",         ev(1,0,1,4'b0100,0,1,1,2'b00,0,0,0,2'b00,0,0));
        drive(6'b101011, 6'b000000, 1'b0);
        check("sw",         ev(0,0,1,4'b0100,1,0,1,2'b00,0,0,0,2'b00,0,0));
        drive(6'b001101, 6'b000000, 1'b0);
        check("ori",        ev(1,0,1,4'b0001,0,0,0,2'b00,0,0,0,2'b00,0,0));
        drive(6'b001010, 6'b000000, 1'b0);
        check("slti",       ev(1,0,1,4'b1101,0,0,1,2'b00,0,0,0,2'b00,0,0));
        drive(RT, 6'b001000, 1'b0);
        check("jr",         ev(0,1,0,4'b0000,0,0,0,2'b00,0,0,0,2'b11,0,0));
        drive(RT, 6'b100111, 1'b0);
        check("nor",        ev(1,1,0,4'b0011,0,0,0,2'b00,0,0,0,2'b00,0,0));
        drive(6'b111111, 6'b000000, 1'b0);
        check("illegal_op", ev(0,0,0,4'b0000,0,0,0,2'b00,0,0,0,2'b00,0,1));

        // mult then mflo: four stalled cycles, then mflo proceeds
        drive(RT, 6'b011000, 1'b0);
        check("mult_start", ev(0,1,0,4'b0000,0,0,0,2'b00,1,1,0,2'b00,0,0));
        drive(RT, 6'b010010, 1'b0);
        for (int i = 0; i < 4; i++)
            check("mflo_stall", ev(0,1,0,4'b0000,0,0,0,2'b10,0,0,0,2'b00,1,0));
        check("mflo_go",    ev(1,1,0,4'b0000,0,0,0,2'b10,0,0,0,2'b00,0,0));

        // mult, unrelated add while busy, second mult held until idle
        drive(RT, 6'b011000, 1'b0);
        check("mult2_start", ev(0,1,0,4'b0000,0,0,0,2'b00,1,1,0,2'b00,0,0));
        drive(RT, 6'b100000, 1'b0);
        check("add_busy",    ev(1,1,0,4'b0100,0,0,0,2'b00,0,0,0,2'b00,0,0));
        drive(RT, 6'b011000, 1'b0);
        for (int i = 0; i < 3; i++)
            check("mult_stall", ev(0,1,0,4'b0000,0,0,0,2'b00,0,1,0,2'b00,1,0));
        check("mult3_start", ev(0,1,0,4'b0000,0,0,0,2'b00,1,1,0,2'b00,0,0));

        // reset two cycles into busy with mfhi held
        drive(RT, 6'b010000, 1'b0);
        check("mfhi_stall0", ev(0,1,0,4'b0000,0,0,0,2'b01,0,0,0,2'b00,1,0));
        check("mfhi_stall1", ev(0,1,0,4'b0000,0,0,0,2'b01,0,0,0,2'b00,1,0));
        reset = 1'b1;
        check("reset_busy",  ZERO);
        reset = 1'b0;
        check("mfhi_after",  ev(1,1,0,4'b0000,0,0,0,2'b01,0,0,0,2'b00,0,0));
        check("mfhi_again",  ev(1,1,0,4'b0000,0,0,0,2'b01,0,0,0,2'b00,0,0));

        drive(RT, 6'b011001, 1'b0);
`ifdef PIPELINE_CTRL_MULTU_EN
        check("multu",       ev(0,1,0,4'b0000,0,0,0,2'b00,1,0,0,2'b00,0,0));
`else
        check("multu_illeg", ev(0,0,0,4'b0000,0,0,0,2'b00,0,0,0,2'b00,0,1));
        drive(RT, 6'b010000, 1'b0);
        check("mfhi_no_seq", ev(1,1,0,4'b0000,0,0,0,2'b01,0,0,0,2'b00,0,0));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
